// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and late results onto one register write port with a pending scoreboard and starvation stall
module writeback_arbiter #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset_N,
    input  logic                        i_Enable,
    input  logic                        i_Alu_Valid,
    input  logic [REG_ADDR_WIDTH-1:0]   i_Alu_Rd,
    input  logic [XLEN-1:0]             i_Alu_Data,
    input  logic                        i_Late_Valid,
    input  logic [REG_ADDR_WIDTH-1:0]   i_Late_Rd,
    input  logic [XLEN-1:0]             i_Late_Data,
    output logic                        o_Late_Ready,
    input  logic                        i_Issue_Valid,
    input  logic [REG_ADDR_WIDTH-1:0]   i_Issue_Rd,
    output logic [2**REG_ADDR_WIDTH-1:0] o_Pending,
    output logic                        o_Stall_Req,
    output logic                        o_Write_Enable,
    output logic [REG_ADDR_WIDTH-1:0]   o_Write_Addr,
    output logic [XLEN-1:0]             o_Write_Data
);
    localparam int NREG = 2**REG_ADDR_WIDTH;
    localparam int CW   = $clog2(STARVE_LIMIT + 1);

    logic                      alu_acc, late_xfer, acc;
    logic                      we_q, we_d, stall_q, stall_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [XLEN-1:0]           data_q, data_d;
    logic [NREG-1:0]           pend_q, pend_d, set_m, clr_m;
    logic [CW-1:0]             cnt_q, cnt_d;

    assign o_Late_Ready   = i_Enable && !i_Alu_Valid;
    assign o_Pending      = pend_q;
    assign o_Stall_Req    = stall_q;
    assign o_Write_Enable = we_q;
    assign o_Write_Addr   = addr_q;
    assign o_Write_Data   = data_q;

    // Select the write source, update the scoreboard and the starvation counter
    always_comb begin
        alu_acc   = i_Enable && i_Alu_Valid;
        late_xfer = i_Late_Valid && o_Late_Ready;
        acc       = alu_acc || late_xfer;
        we_d      = (alu_acc && i_Alu_Rd != '0) || (late_xfer && i_Late_Rd != '0);
        addr_d    = alu_acc ? i_Alu_Rd : late_xfer ? i_Late_Rd : addr_q;
        data_d    = alu_acc ? i_Alu_Data : late_xfer ? i_Late_Data : data_q;
        set_m     = (i_Enable && i_Issue_Valid) ? (NREG'(1) << i_Issue_Rd) : '0;
        clr_m     = late_xfer ? (NREG'(1) << i_Late_Rd) : '0;
        pend_d    = ((pend_q & ~clr_m) | set_m) & ~NREG'(1);
        cnt_d     = !i_Enable ? cnt_q :
                    (!i_Late_Valid || late_xfer) ? '0 :
                    (cnt_q == CW'(STARVE_LIMIT)) ? cnt_q : cnt_q + CW'(1);
        stall_d   = cnt_d == CW'(STARVE_LIMIT);
    end

    // State registers; reset discards any coincident transfer
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= acc ? addr_d : addr_q;
            data_q  <= data_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, en;
    logic        alu_v, late_v, issue_v;
    logic [4:0]  alu_rd, late_rd, issue_rd;
    logic [31:0] alu_d, late_d;
    logic        late_rdy, stall, we;
    logic [31:0] pend;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          n_chk = 0;
    int          n_pass = 0;

    writeback_arbiter dut (
        .i_Clock(clk), .i_Reset_N(rst_n), .i_Enable(en),
        .i_Alu_Valid(alu_v), .i_Alu_Rd(alu_rd), .i_Alu_Data(alu_d),
        .i_Late_Valid(late_v), .i_Late_Rd(late_rd), .i_Late_Data(late_d),
        .o_Late_Ready(late_rdy), .i_Issue_Valid(issue_v), .i_Issue_Rd(issue_rd),
        .o_Pending(pend), .o_Stall_Req(stall), .o_Write_Enable(we),
        .o_Write_Addr(waddr), .o_Write_Data(wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; en = 1; alu_v = 0; late_v = 0; issue_v = 0;
        alu_rd = 0; late_rd = 0; issue_rd = 0; alu_d = 0; late_d = 0;
        tick();
        check("rst_we", we, 0);
        check("rst_addr", waddr, 0);
        check("rst_data", wdata, 0);
        check("rst_pend", pend, 0);
        check("rst_stall", stall, 0);
        rst_n = 1;
        // ALU write
        alu_v = 1; alu_rd = 5; alu_d = 32'hDEADBEEF;
        #1 check("alu_rdy", late_rdy, 0);
        tick();
        check("alu_we", we, 1);
        check("alu_addr", waddr, 5);
        check("alu_data", wdata, 32'hDEADBEEF);
        alu_v = 0;
        tick();
        check("alu_we_drop", we, 0);
        check("alu_addr_hold", waddr, 5);
        check("alu_data_hold", wdata, 32'hDEADBEEF);
        // Issue then late write to r7
        issue_v = 1; issue_rd = 7;
        tick();
        issue_v = 0;
        check("pend7_set", pend, 32'h80);
        tick();
        check("pend7_hold", pend, 32'h80);
        late_v = 1; late_rd = 7; late_d = 32'h12;
        #1 check("late_rdy", late_rdy, 1);
        tick();
        late_v = 0;
        check("late_we", we, 1);
        check("late_addr", waddr, 7);
        check("late_data", wdata, 32'h12);
        check("pend7_clr", pend, 0);
        // Starvation: late held behind ALU
        late_v = 1; late_rd = 3; late_d = 32'h33;
        alu_v = 1; alu_rd = 1; alu_d = 32'h11;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("stall_low_%0d", i), stall, 0);
        end
        check("starve_alu_addr", waddr, 1);
        tick();
        check("stall_4", stall, 1);
        tick();
        check("stall_sat", stall, 1);
        alu_v = 0;
        tick();
        late_v = 0;
        check("starve_xfer_we", we, 1);
        check("starve_xfer_addr", waddr, 3);
        check("starve_xfer_data", wdata, 32'h33);
        check("stall_clr", stall, 0);
        // Set wins over clear on r9
        issue_v = 1; issue_rd = 9;
        tick();
        check("pend9_set", pend, 32'h200);
        late_v = 1; late_rd = 9; late_d = 32'h99;
        tick();
        issue_v = 0;
        check("pend9_setwins", pend, 32'h200);
        check("pend9_we", we, 1);
        tick();
        late_v = 0;
        check("pend9_clr", pend, 0);
        // rd=0 handling
        alu_v = 1; alu_rd = 0; alu_d = 32'hFFFFFFFF;
        tick();
        alu_v = 0;
        check("rd0_we", we, 0);
        issue_v = 1; issue_rd = 0;
        tick();
        issue_v = 0;
        check("rd0_pend", pend, 0);
        // Enable low: everything holds
        en = 0; issue_v = 1; issue_rd = 4; late_v = 1; late_rd = 2;
        #1 check("dis_rdy", late_rdy, 0);
        tick();
        check("dis_pend", pend, 0);
        check("dis_we", we, 0);
        // Build up pending bit and stall, then reset
        en = 1; late_v = 0;
        tick();
        issue_v = 0;
        check("pend4_set", pend, 32'h10);
        late_v = 1; late_rd = 4; late_d = 32'h44; alu_v = 1; alu_rd = 2;
        repeat (4) tick();
        check("pre_rst_stall", stall, 1);
        rst_n = 0; alu_v = 0;
        tick();
        check("post_rst_we", we, 0);
        check("post_rst_addr", waddr, 0);
        check("post_rst_data", wdata, 0);
        check("post_rst_pend", pend, 0);
        check("post_rst_stall", stall, 0);
        rst_n = 1; late_v = 0;
        tick();
        check("post_rst_idle_we", we, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
